ov7670_sccb: RTL and testbench

OV7670_SCCB -- requirements
Module: ov7670_sccb

---
 rtl/ov7670_sccb.sv | 118 +++++++++++
 tb/tb_ov7670_sccb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb.sv
// ov7670_sccb: 3-phase SCCB write master (ID, register address, value) for OV7670 init.
// Define OV7670_SCCB_ACK_CHECK_EN to sample SIOD during the don't-care bits and flag a missing ack on nack.
module ov7670_sccb #(
    parameter int          QUARTER  = 250,
    parameter logic [7:0]  SLAVE_ID = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data,
    input  logic        siod_in,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        busy,
    output logic        done,
    output logic        nack
);
    typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] qcnt_q, qcnt_d;
    logic [1:0]  qidx_q, qidx_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [15:0] dat_q, dat_d;
    logic        nack_q, nack_d;
    logic [26:0] frame;
    logic        is_x;
    logic        qend;
    assign frame = {SLAVE_ID, 1'b1, dat_q[15:8], 1'b1, dat_q[7:0], 1'b1};
    assign is_x  = (bcnt_q == 5'd8) || (bcnt_q == 5'd17) || (bcnt_q == 5'd26);
    assign qend  = qcnt_q == 16'(QUARTER - 1);
`ifndef OV7670_SCCB_ACK_CHECK_EN
    logic unused_siod;
    assign unused_siod = siod_in;
`endif
    // state and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            qidx_q  <= '0;
            bcnt_q  <= '0;
            dat_q   <= '0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qidx_q  <= qidx_d;
            bcnt_q  <= bcnt_d;
            dat_q   <= dat_d;
            nack_q  <= nack_d;
        end
    end
    // phase sequencing: each phase is four quarters, BITS repeats for 27 bits
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qidx_d  = qidx_q;
        bcnt_d  = bcnt_q;
        dat_d   = dat_q;
        nack_d  = nack_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = START;
                dat_d   = data;
                nack_d  = 1'b0;
                qcnt_d  = '0;
                qidx_d  = '0;
                bcnt_d  = '0;
            end
            DONE: state_d = IDLE;
            default: begin
                qcnt_d = qend ? '0 : qcnt_q + 16'd1;
                if (qend) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        state_d = state_q == START ? BITS :
                                  state_q == STOP  ? DONE :
                                  bcnt_q == 5'd26  ? STOP : BITS;
                        bcnt_d  = (state_q == BITS && bcnt_q != 5'd26) ? bcnt_q + 5'd1 : '0;
                    end
                end
`ifdef OV7670_SCCB_ACK_CHECK_EN
                if (state_q == BITS && is_x && qidx_q == 2'd2 && qcnt_q == '0 && siod_in)
                    nack_d = 1'b1;
`endif
            end
        endcase
    end
    // pad waveforms decoded from phase, quarter index and bit position
    always_comb begin
        sioc     = 1'b1;
        siod_out = 1'b1;
        siod_oe  = 1'b0;
        case (state_q)
            START: begin
                sioc     = qidx_q != 2'd3;
                siod_out = ~qidx_q[1];
                siod_oe  = 1'b1;
            end
            BITS: begin
                sioc     = qidx_q[1];
                siod_out = frame[5'd26 - bcnt_q];
                siod_oe  = ~is_x;
            end
            STOP: begin
                sioc     = qidx_q != 2'd0;
                siod_out = qidx_q[1];
                siod_oe  = 1'b1;
            end
            DONE: siod_oe = 1'b1;
            default: ;
        endcase
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign nack = nack_q;
endmodule

// File: tb/tb_ov7670_sccb.sv
// tb_ov7670_sccb: scoreboard bench decoding the SCCB wire and checking each completed write.
module tb_ov7670_sccb;
    localparam int Q = 4;
`ifdef OV7670_SCCB_ACK_CHECK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        siod_in = 1'b0;
    logic [15:0] data = '0;
    logic        sioc, siod_out, siod_oe, busy, done, nack;

    ov7670_sccb #(.QUARTER(Q), .SLAVE_ID(8'h42)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .siod_in(siod_in),
        .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe),
        .busy(busy), .done(done), .nack(nack)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] d; int gap; logic nk;} exp_t;
    exp_t        sb[$];
    exp_t        em;
    int          checks = 0, errors = 0, cyc = 0, ndone = 0, viol = 0;
    int          accept_cyc = 0, last_done = 0, nb = 0;
    logic [26:0] bits = '0, oes = '0, x_mask;
    bit          collecting = 0, stop_seen = 0;
    logic        ps = 1'b1, pd = 1'b1, pb = 1'b0;

    initial x_mask = ~((27'd1 << 18) | (27'd1 << 9) | 27'd1);

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: decode START, 27 bits and STOP off the wire; compare on every done pulse
    always @(negedge clk) begin
        if (reset) begin
            collecting = 0;
            nb = 0;
            stop_seen = 0;
        end else begin
            if (!busy && (siod_oe || !sioc || !siod_out)) viol++;
            if (busy && !siod_oe && !collecting) viol++;
            if (busy && !pb) accept_cyc = cyc - 1;
            if (siod_oe && sioc && ps && pd && !siod_out) begin
                collecting = 1;
                nb = 0;
                stop_seen = 0;
            end else if (collecting && sioc && !ps && nb < 27) begin
                bits[26 - nb] = siod_out;
                oes[26 - nb]  = siod_oe;
                nb++;
            end else if (collecting && nb == 27 && sioc && ps && !pd && siod_out)
                stop_seen = 1;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got done=1 expected no transaction");
                end else begin
                    em = sb.pop_front();
                    chk("bit_count", nb, 27);
                    chk("slave_id", int'(bits[26:19]), 8'h42);
                    chk("addr_byte", int'(bits[17:10]), int'(em.d[15:8]));
                    chk("value_byte", int'(bits[8:1]), int'(em.d[7:0]));
                    chk("oe_pattern", int'(oes), int'(x_mask));
                    chk("stop_seen", int'(stop_seen), 1);
                    chk("latency", cyc - accept_cyc, 116 * Q + 1);
                    if (em.gap != 0) chk("done_gap", cyc - last_done, em.gap);
                    chk("nack_at_done", int'(nack), int'(em.nk));
                end
                last_done = cyc;
                ndone++;
                collecting = 0;
            end
        end
        ps = sioc;
        pd = siod_out;
        pb = busy;
    end

    task automatic issue(input logic [15:0] d);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (ndone < n && t < 1500) begin
            @(negedge clk);
            t++;
        end
        chk("done_count", ndone, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sioc", int'(sioc), 1);
        chk("rst_siod_out", int'(siod_out), 1);
        chk("rst_siod_oe", int'(siod_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_nack", int'(nack), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back('{16'h1280, 0, 1'b0});
        issue(16'h1280);
        chk("busy_after_accept", int'(busy), 1);
        wait_done(1);
        sb.push_back('{16'h1234, 0, 1'b0});
        sb.push_back('{16'h1234, 116 * Q + 2, 1'b0});
        @(negedge clk);
        data  = 16'h1234;
        start = 1'b1;
        repeat (116 * Q + 3) @(negedge clk);
        start = 1'b0;
        wait_done(3);
        sb.push_back('{16'h1280, 0, 1'b0});
        issue(16'h1280);
        repeat (100) @(negedge clk);
        data = 16'hFFFF;
        wait_done(4);
        issue(16'h5555);
        repeat (180) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sioc", int'(sioc), 1);
        chk("abort_siod_oe", int'(siod_oe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        repeat (500) @(negedge clk);
        chk("no_done_after_abort", ndone, 4);
        sb.push_back('{16'hA55A, 0, ACK});
        issue(16'hA55A);
        repeat (290) @(negedge clk);
        siod_in = 1'b1;
        repeat (12) @(negedge clk);
        siod_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("nack_after_x2", int'(nack), int'(ACK));
        wait_done(5);
        sb.push_back('{16'h0F0F, 0, 1'b0});
        issue(16'h0F0F);
        chk("nack_cleared", int'(nack), 0);
        wait_done(6);
        repeat (600) @(negedge clk);
        chk("total_done", ndone, 6);
        chk("scoreboard_empty", sb.size(), 0);
        chk("oe_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
